// File: rtl/fetch_pc_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_controller_if
// Purpose  : Fetch-control bundle between the pipeline (EX branch resolution,
//            ID interlock, halt) and the fetch PC controller outputs.
//            Optional perf counters appear when FETCH_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_controller_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              is_Branch_Taken;
  logic [ADDR_W-1:0] branchPC;
  logic              isDataInterLock;
  logic              halt_req;
  logic [ADDR_W-1:0] pc_out;
  logic              fetch_valid;
  logic              flush_IF_ID;
  logic              fault;
  logic [2:0]        state;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;
`endif

  // Pipeline side: issues requests, observes fetch controls
  modport master (
    output start, is_Branch_Taken, branchPC, isDataInterLock, halt_req,
`ifdef FETCH_PERF_EN
    input  perf_stall_cnt, perf_flush_cnt,
`endif
    input  pc_out, fetch_valid, flush_IF_ID, fault, state
  );

  // Controller side
  modport slave (
    input  start, is_Branch_Taken, branchPC, isDataInterLock, halt_req,
`ifdef FETCH_PERF_EN
    output perf_stall_cnt, perf_flush_cnt,
`endif
    output pc_out, fetch_valid, flush_IF_ID, fault, state
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_controller
// Purpose  : Owns the fetch PC; each cycle increments, holds (interlock),
//            redirects (branch + IF_ID flush bubbles) or halts. Illegal fetch
//            targets (misaligned, beyond IMEM, sequential overrun) trap into
//            HALT with a sticky fault.
// Config   : FETCH_PERF_EN adds saturating stall / redirect counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_controller #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                IMEM_WORDS   = 1024,
  parameter int                FLUSH_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_pc_controller_if.slave bus
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_RUN   = 3'd1;
  localparam logic [2:0] c_ST_STALL = 3'd2;
  localparam logic [2:0] c_ST_FLUSH = 3'd3;
  localparam logic [2:0] c_ST_HALT  = 3'd4;

  // First byte address past the instruction memory, and the last legal PC
  localparam logic [ADDR_W-1:0] c_PC_LIMIT   = ADDR_W'(IMEM_WORDS * 4);
  localparam logic [ADDR_W-1:0] c_LAST_PC    = ADDR_W'(IMEM_WORDS * 4 - 4);
  localparam logic [2:0]        c_FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_fetch_valid;
  logic              r_flush;
  logic              r_fault;
  logic [2:0]        r_flush_left;

  logic [2:0]        w_state;
  logic [ADDR_W-1:0] w_pc;
  logic              w_fetch_valid;
  logic              w_flush;
  logic              w_fault;
  logic [2:0]        w_flush_left;
  logic              w_redirect;
  logic              w_branch_legal;
  logic              w_seq_legal;
  logic [ADDR_W-1:0] w_pc_inc;

  // Target legality and the sequential adder (carry discarded; the range
  // check traps before the adder could ever overflow)
  always_comb begin
    w_branch_legal = (bus.branchPC[1:0] == 2'b00) && (bus.branchPC < c_PC_LIMIT);
    w_seq_legal    = (r_pc < c_LAST_PC);
    w_pc_inc       = r_pc + ADDR_W'(4);
  end

  // Next-state decision: halt > branch > interlock > increment
  always_comb begin
    w_state       = r_state;
    w_pc          = r_pc;
    w_fetch_valid = 1'b0;
    w_flush       = 1'b0;
    w_fault       = r_fault;
    w_flush_left  = r_flush_left;
    w_redirect    = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.start) begin
          w_state       = c_ST_RUN;
          w_fetch_valid = 1'b1;
        end
      end
      c_ST_RUN, c_ST_STALL, c_ST_FLUSH: begin
        if (bus.halt_req) begin
          w_state = c_ST_HALT;
        end else if (bus.is_Branch_Taken) begin
          if (w_branch_legal) begin
            // Redirect: new target appears now, bubbles keep IF_ID clear
            w_pc         = bus.branchPC;
            w_state      = c_ST_FLUSH;
            w_flush      = 1'b1;
            w_flush_left = c_FLUSH_LOAD;
            w_redirect   = 1'b1;
          end else begin
            w_fault = 1'b1;
            w_state = c_ST_HALT;
          end
        end else if (r_state == c_ST_FLUSH) begin
          // Interlock is irrelevant while the pipe front is being bubbled
          if (r_flush_left <= 3'd1) begin
            w_state       = c_ST_RUN;
            w_fetch_valid = 1'b1;
          end else begin
            w_flush_left = r_flush_left - 3'd1;
            w_flush      = 1'b1;
          end
        end else if (bus.isDataInterLock) begin
          w_state       = c_ST_STALL;
          w_fetch_valid = 1'b1;
        end else if (w_seq_legal) begin
          w_pc          = w_pc_inc;
          w_state       = c_ST_RUN;
          w_fetch_valid = 1'b1;
        end else begin
          // Falling off the end of IMEM is a trap, never a wrap to 0
          w_fault = 1'b1;
          w_state = c_ST_HALT;
        end
      end
      c_ST_HALT: begin
        w_state = c_ST_HALT;
      end
      default: begin
        w_state = c_ST_HALT;
        w_fault = 1'b1;
      end
    endcase
  end

  // Output and state registers; reset wins in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_ST_IDLE;
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_fault       <= 1'b0;
      r_flush_left  <= 3'd0;
    end else begin
      r_state       <= w_state;
      r_pc          <= w_pc;
      r_fetch_valid <= w_fetch_valid;
      r_flush       <= w_flush;
      r_fault       <= w_fault;
      r_flush_left  <= w_flush_left;
    end
  end

  assign bus.pc_out      = r_pc;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.flush_IF_ID = r_flush;
  assign bus.fault       = r_fault;
  assign bus.state       = r_state;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Saturating counters: cycles spent in STALL, accepted redirects
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall_cnt <= 32'd0;
      r_perf_flush_cnt <= 32'd0;
    end else begin
      if ((r_state == c_ST_STALL) && (r_perf_stall_cnt != 32'hFFFF_FFFF))
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (w_redirect && (r_perf_flush_cnt != 32'hFFFF_FFFF))
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall_cnt;
  assign bus.perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
`default_nettype wire
